bpeb_term_dec: RTL and testbench
================================

Name: bpeb_term_dec

Overview:
- Consumer side of the bit-pair (radix-4 Booth) encoded operand produced by the PE's encoder.
- Accepts one 24-bit BPR word plus its essential-term count (ETC).
- Serially emits one essential term per handshake, LSB group first, as shift amount, sign and last flag.
- Drives the term-serial multiply path of the FoFIR PE.

Parameters:
- N_GROUP, 8, number of 3-bit Booth groups per BPR word.
- DATA_W, 16, operand width; must equal 2*N_GROUP.
- SHIFT_W, 4, width of term_shift; must satisfy 2^SHIFT_W >= DATA_W.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  BPR word valid.
- in_ready  out  1  decoder can accept a word.
- in_bpr  in  3*N_GROUP  group i = bits [3i+2:3i] = {b(2i+1), b(2i), b(2i-1)}.
- in_etc  in  4  essential-term count supplied with the word.
- out_valid  out  1  term valid.
- out_ready  in  1  downstream accepts the term.
- term_shift  out  SHIFT_W  left-shift of the term magnitude (power of two).
- term_neg  out  1  term is negative.
- term_zero  out  1  word had no essential terms; shift/neg are don't-care.
- term_last  out  1  final term of the current word.
- etc_err  out  1  sticky flag: ETC mismatch seen.

Behaviour:
- Group digit decode:
  - 000 and 111 -> 0, non-essential.
  - 001 and 010 -> +1, shift 2i.
  - 011 -> +2, shift 2i+1.
  - 100 -> -2, shift 2i+1, neg.
  - 101 and 110 -> -1, shift 2i, neg.
- States: IDLE, EMIT, ZERO.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: register in_bpr and the 8-bit essential mask.
  - Mask nonzero -> EMIT; mask zero -> ZERO.
- EMIT:
  - out_valid=1. Outputs come from the lowest set mask bit (priority encoder).
  - term_last=1 when exactly one mask bit remains.
  - On out_valid&&out_ready: clear that mask bit. If term_last, return to IDLE unless a new word is accepted in the same cycle.
- ZERO:
  - out_valid=1, term_zero=1, term_last=1, term_shift=0, term_neg=0.
  - On handshake, behaves the same as a last-term handshake.
- Back-to-back acceptance:
  - in_ready = (state==IDLE) || (out_valid && out_ready && term_last). This is a combinational path from out_ready.
  - A word accepted on a last-term handshake loads directly into EMIT/ZERO. There is no IDLE bubble.
- Latency: first term is valid the cycle after acceptance.
- Throughput: one term per cycle while out_ready=1. A word with k essential terms occupies max(k,1) output handshakes.
- Stall: while out_valid=1 and out_ready=0, all term outputs and the mask hold stable.
- ETC check:
  - At acceptance, popcount(essential mask) != in_etc sets etc_err.
  - etc_err is sticky until rst. Emission is unaffected; the mask is authoritative.
- Reset (any time, including mid-word):
  - state=IDLE, mask=0, out_valid=0, term_shift=0, term_neg=0, term_zero=0, term_last=0, etc_err=0.
  - in_ready=1 once rst deasserts.
  - A partially emitted word is discarded.
- Zeroed low groups (approximate-computing truncation) are ordinary 000 groups: non-essential and skipped.

Optional Feature:
- Macro: BPEB_TERM_DEC_RECON_EN.
- Defined:
  - Adds outputs recon_valid (1) and recon_value (DATA_W).
  - A 17-bit signed accumulator clears at word acceptance and adds ±(1<<term_shift) on each term handshake.
  - On the last/zero handshake, recon_value takes the final sum (low DATA_W bits) and recon_valid pulses high for 1 cycle.
  - Reset values: recon_value=0, recon_valid=0.
- Undefined: the ports and accumulator are absent; all other behaviour is identical.

Decomposition:
- Package bpeb_pkg holds:
  - N_GROUP, DATA_W, SHIFT_W.
  - Booth group code constants (GRP_P1A=001, GRP_P1B=010, GRP_P2=011, GRP_N2=100, GRP_N1A=101, GRP_N1B=110).
  - The state enum.
- Sub-module bpeb_grp_dec: purely combinational 3-bit group -> {essential, neg, mag2}, instantiated N_GROUP times.
- Priority-encode and FSM stay in the top module.

Test Plan:
- BPR of 16'h0001 (group0=010), in_etc=1, out_ready=1 -> one term: shift 0, neg 0, last 1. etc_err stays 0. With RECON, recon_value=1.
- BPR of 16'h0003 (group0=110, group1=001), in_etc=2 -> term {shift0, neg1, last0} then {shift2, neg0, last1}. RECON gives 3.
- BPR of 16'h7FFF (group0=110, groups1-6=111, group7=011) -> {shift0, neg1} then {shift15, neg0, last1}. RECON gives 32767.
- BPR of 16'h0000 with in_etc=0, and of 16'hFFFF with group0 forced to 000 -> single term_zero=1, last=1 handshake each.
- Back-to-back words with out_ready toggling 1,0,1,1 -> outputs hold during stall. The second word is accepted on the last-term handshake, and its first term appears the next cycle.
- 16'h0003 with in_etc=3 -> etc_err rises the cycle after acceptance and stays 1. rst asserted after the first term -> out_valid=0 and in_ready=1 after release, and the remaining term is never emitted.

Source files
------------

// File: rtl/bpeb_pkg.sv
// bpeb_pkg: shared sizes, Booth group codes, FSM states and term payload for
// the bit-pair encoded operand term decoder.
// No ports; imported by bpeb_grp_dec and bpeb_term_dec.
package bpeb_pkg;

    localparam int unsigned N_GROUP = 8;
    localparam int unsigned DATA_W  = 2 * N_GROUP;
    localparam int unsigned SHIFT_W = 4;
    localparam int unsigned BPR_W   = 3 * N_GROUP;
    localparam int unsigned ETC_W   = 4;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned ACC_W   = DATA_W + 1;

    // Booth group codes {b(2i+1), b(2i), b(2i-1)}; 000 and 111 are zero digits.
    localparam logic [2:0] GRP_P1A = 3'b001;
    localparam logic [2:0] GRP_P1B = 3'b010;
    localparam logic [2:0] GRP_P2  = 3'b011;
    localparam logic [2:0] GRP_N2  = 3'b100;
    localparam logic [2:0] GRP_N1A = 3'b101;
    localparam logic [2:0] GRP_N1B = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_ZERO = 2'd2
    } state_t;

    // One emitted term as presented on the output port group.
    typedef struct packed {
        logic [SHIFT_W-1:0] shift;
        logic               neg;
        logic               zero;
        logic               last;
    } term_t;

    // Number of set bits in an essential-term mask.
    function automatic logic [ETC_W-1:0] popcount(input logic [N_GROUP-1:0] m);
        logic [ETC_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < int'(N_GROUP); i++) begin
            cnt = cnt + ETC_W'(m[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/bpeb_grp_dec.sv
// bpeb_grp_dec: combinational decode of one 3-bit Booth group.
// Ports: grp (group code), essential (digit is nonzero),
//        neg (digit is negative), mag2 (|digit| == 2, adds one to the shift).
module bpeb_grp_dec
    import bpeb_pkg::*;
(
    input  logic [2:0] grp,
    output logic       essential,
    output logic       neg,
    output logic       mag2
);

    always_comb begin
        essential = 1'b0;
        neg       = 1'b0;
        mag2      = 1'b0;
        case (grp)
            GRP_P1A, GRP_P1B: essential = 1'b1;
            GRP_P2: begin
                essential = 1'b1;
                mag2      = 1'b1;
            end
            GRP_N2: begin
                essential = 1'b1;
                neg       = 1'b1;
                mag2      = 1'b1;
            end
            GRP_N1A, GRP_N1B: begin
                essential = 1'b1;
                neg       = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/bpeb_term_dec.sv
// bpeb_term_dec: accepts one BPR word plus essential-term count and emits its
// essential terms one per handshake, lowest group first.
// Ports: clk, rst (async, active-high); in_valid/in_ready/in_bpr/in_etc word
//        input; out_valid/out_ready handshake with term_shift, term_neg,
//        term_zero, term_last; etc_err sticky count-mismatch flag.
// Optional: BPEB_TERM_DEC_RECON_EN adds recon_valid/recon_value, the word
//        value rebuilt from the emitted terms.
module bpeb_term_dec
    import bpeb_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BPR_W-1:0]   in_bpr,
    input  logic [ETC_W-1:0]   in_etc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SHIFT_W-1:0] term_shift,
    output logic               term_neg,
    output logic               term_zero,
    output logic               term_last,
    output logic               etc_err
`ifdef BPEB_TERM_DEC_RECON_EN
    ,
    output logic               recon_valid,
    output logic [DATA_W-1:0]  recon_value
`endif
);

    state_t               state, state_nxt;
    logic [N_GROUP-1:0]   mask, mask_nxt;
    logic [N_GROUP-1:0]   neg_v, neg_nxt;
    logic [N_GROUP-1:0]   mag2_v, mag2_nxt;
    logic [N_GROUP-1:0]   ess_in, neg_in, mag2_in;
    term_t                term_q, term_nxt;
    logic                 valid_nxt;
    logic                 err_nxt;
    logic [IDX_W-1:0]     sel;
    logic                 hs, done, accept;

    // Per-group digit decode of the incoming word.
    for (genvar g = 0; g < int'(N_GROUP); g++) begin : g_dec
        bpeb_grp_dec u_grp_dec (
            .grp       (in_bpr[3*g +: 3]),
            .essential (ess_in[g]),
            .neg       (neg_in[g]),
            .mag2      (mag2_in[g])
        );
    end

    // A last-term handshake frees the decoder for a new word in the same cycle.
    assign hs       = out_valid && out_ready;
    assign done     = hs && term_last;
    assign in_ready = (state == ST_IDLE) || done;
    assign accept   = in_valid && in_ready;

    // Next state and next registered term, priority-encoded from the next mask.
    always_comb begin
        state_nxt = state;
        mask_nxt  = mask;
        neg_nxt   = neg_v;
        mag2_nxt  = mag2_v;
        err_nxt   = etc_err;
        term_nxt  = '0;
        valid_nxt = 1'b0;
        sel       = '0;

        if (hs) begin
            mask_nxt = mask & (mask - N_GROUP'(1));  // drop lowest set bit
        end
        if (done) begin
            state_nxt = ST_IDLE;
        end
        if (accept) begin
            mask_nxt  = ess_in;
            neg_nxt   = neg_in;
            mag2_nxt  = mag2_in;
            state_nxt = (|ess_in) ? ST_EMIT : ST_ZERO;
            if (popcount(ess_in) != in_etc) begin
                err_nxt = 1'b1;
            end
        end

        case (state_nxt)
            ST_EMIT: begin
                valid_nxt = 1'b1;
                for (int i = int'(N_GROUP) - 1; i >= 0; i--) begin
                    if (mask_nxt[i]) begin
                        sel = IDX_W'(i);
                    end
                end
                // shift = 2*group + (|digit| == 2)
                term_nxt.shift = SHIFT_W'({sel, mag2_nxt[sel]});
                term_nxt.neg   = neg_nxt[sel];
                term_nxt.last  = ((mask_nxt & (mask_nxt - N_GROUP'(1))) == '0);
            end
            ST_ZERO: begin
                valid_nxt     = 1'b1;
                term_nxt.zero = 1'b1;
                term_nxt.last = 1'b1;
            end
            default: ;
        endcase
    end

    // State, mask and registered term outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            mask      <= '0;
            neg_v     <= '0;
            mag2_v    <= '0;
            out_valid <= 1'b0;
            term_q    <= '0;
            etc_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            mask      <= mask_nxt;
            neg_v     <= neg_nxt;
            mag2_v    <= mag2_nxt;
            out_valid <= valid_nxt;
            term_q    <= term_nxt;
            etc_err   <= err_nxt;
        end
    end

    assign term_shift = term_q.shift;
    assign term_neg   = term_q.neg;
    assign term_zero  = term_q.zero;
    assign term_last  = term_q.last;

`ifdef BPEB_TERM_DEC_RECON_EN
    logic [ACC_W-1:0] acc, acc_nxt, acc_sum, term_mag, term_val;

    // Signed running sum of emitted terms, modulo 2^ACC_W.
    always_comb begin
        term_mag = ACC_W'(1) << term_shift;
        term_val = '0;
        if (!term_zero) begin
            term_val = term_neg ? (~term_mag + ACC_W'(1)) : term_mag;
        end
        acc_sum = acc + term_val;
        acc_nxt = acc;
        if (hs) begin
            acc_nxt = acc_sum;
        end
        if (accept) begin
            acc_nxt = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc         <= '0;
            recon_valid <= 1'b0;
            recon_value <= '0;
        end else begin
            acc         <= acc_nxt;
            recon_valid <= done;
            if (done) begin
                recon_value <= acc_sum[DATA_W-1:0];
            end
        end
    end
`endif

endmodule

// File: tb/tb_bpeb_term_dec.sv
// tb_bpeb_term_dec: randomized and directed stimulus against a queue-based
// term model derived from the Booth digit value of each group.
module tb_bpeb_term_dec;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] in_bpr = '0;
    logic [3:0]  in_etc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  term_shift;
    logic        term_neg, term_zero, term_last, etc_err;
`ifdef BPEB_TERM_DEC_RECON_EN
    logic        recon_valid;
    logic [15:0] recon_value;
`endif

    bpeb_term_dec dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_bpr     (in_bpr),
        .in_etc     (in_etc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .term_shift (term_shift),
        .term_neg   (term_neg),
        .term_zero  (term_zero),
        .term_last  (term_last),
        .etc_err    (etc_err)
`ifdef BPEB_TERM_DEC_RECON_EN
        ,
        .recon_valid(recon_valid),
        .recon_value(recon_value)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          shift;
        bit          neg;
        bit          zero;
        bit          last;
        logic [15:0] recon;
    } mterm_t;

    typedef struct {
        logic [23:0] bpr;
        logic [3:0]  etc;
    } stim_t;

    mterm_t      q[$];
    stim_t       sq[$];
    int          nvec = 0;
    int          nerr = 0;
    bit          m_err = 0;
    bit          rpend = 0;
    logic [15:0] rval = '0;

    task automatic check(input string tag, input int obs, input int exp);
        nvec++;
        if (obs != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Booth bit-pair encoding of a 16-bit operand.
    function automatic logic [23:0] enc(input logic [15:0] x);
        logic [16:0] xe;
        logic [23:0] b;
        xe = {x, 1'b0};
        for (int i = 0; i < 8; i++) b[3*i +: 3] = xe[2*i +: 3];
        return b;
    endfunction

    // Append the expected terms of a word; returns its essential-term count.
    function automatic int expand(input logic [23:0] bpr);
        int     n, d, sum;
        logic [2:0] g;
        mterm_t t;
        n = 0;
        sum = 0;
        for (int i = 0; i < 8; i++) begin
            g = bpr[3*i +: 3];
            d = -2 * int'(g[2]) + int'(g[1]) + int'(g[0]);
            sum += d * (1 << (2 * i));
            if (d != 0) begin
                t.shift = 2 * i + ((d == 2 || d == -2) ? 1 : 0);
                t.neg   = (d < 0);
                t.zero  = 0;
                t.last  = 0;
                t.recon = '0;
                q.push_back(t);
                n++;
            end
        end
        if (n == 0) begin
            t.shift = 0; t.neg = 0; t.zero = 1; t.last = 1; t.recon = '0;
            q.push_back(t);
        end else begin
            q[q.size()-1].last = 1;
        end
        q[q.size()-1].recon = 16'(sum);
        return n;
    endfunction

    function automatic logic [3:0] ones(input logic [23:0] bpr);
        int n;
        logic [2:0] g;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            g = bpr[3*i +: 3];
            if (g != 3'b000 && g != 3'b111) n++;
        end
        return 4'(n);
    endfunction

    // One cycle: drive inputs after negedge, check, update model, advance.
    task automatic step(input logic iv, input logic [23:0] bpr, input logic [3:0] etc,
                        input logic ordy, output logic acc);
        logic exp_rdy;
        int   n;
        in_valid  = iv;
        in_bpr    = bpr;
        in_etc    = etc;
        out_ready = ordy;
        #1;
        check("out_valid", int'(out_valid), int'(q.size() != 0));
        check("etc_err", int'(etc_err), int'(m_err));
`ifdef BPEB_TERM_DEC_RECON_EN
        check("recon_valid", int'(recon_valid), int'(rpend));
        if (rpend) check("recon_value", int'(recon_value), int'(rval));
`endif
        rpend = 0;
        exp_rdy = (q.size() == 0) || (ordy && q[0].last);
        check("in_ready", int'(in_ready), int'(exp_rdy));
        if (q.size() != 0) begin
            check("term_shift", int'(term_shift), q[0].shift);
            check("term_neg", int'(term_neg), int'(q[0].neg));
            check("term_zero", int'(term_zero), int'(q[0].zero));
            check("term_last", int'(term_last), int'(q[0].last));
            if (ordy) begin
                if (q[0].last) begin
                    rpend = 1;
                    rval  = q[0].recon;
                end
                void'(q.pop_front());
            end
        end
        acc = iv && exp_rdy;
        if (acc) begin
            n = expand(bpr);
            if (n != int'(etc)) m_err = 1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        q.delete();
        m_err = 0;
        rpend = 0;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_term_shift", int'(term_shift), 0);
        check("rst_term_flags", int'({term_neg, term_zero, term_last}), 0);
        check("rst_etc_err", int'(etc_err), 0);
`ifdef BPEB_TERM_DEC_RECON_EN
        check("rst_recon", int'({recon_valid, recon_value}), 0);
`endif
    endtask

    // Offer queued words back to back with a repeating out_ready pattern.
    task automatic drain(input logic [3:0] pat);
        int   c;
        logic iv, acc;
        c = 0;
        while ((sq.size() != 0 || q.size() != 0) && c < 2000) begin
            iv = (sq.size() != 0);
            step(iv, iv ? sq[0].bpr : 24'h0, iv ? sq[0].etc : 4'h0, pat[c % 4], acc);
            if (acc) void'(sq.pop_front());
            c++;
        end
        if (c >= 2000) check("drain_timeout", 1, 0);
    endtask

    initial begin
        logic  acc;
        stim_t s;
        int    c;

        @(negedge clk);
        do_reset();

        // Single-word directed cases.
        s.bpr = enc(16'h0001); s.etc = 4'd1; sq.push_back(s); drain(4'b1111);
        s.bpr = enc(16'h0003); s.etc = 4'd2; sq.push_back(s); drain(4'b1111);
        s.bpr = enc(16'h7FFF); s.etc = 4'd2; sq.push_back(s); drain(4'b1111);
        s.bpr = enc(16'h0000); s.etc = 4'd0; sq.push_back(s);
        s.bpr = enc(16'hFFFF) & ~24'h7; s.etc = 4'd0; sq.push_back(s);
        drain(4'b1111);

        // Back-to-back words with out_ready 1,0,1,1.
        s.bpr = enc(16'h0003); s.etc = 4'd2; sq.push_back(s);
        s.bpr = enc(16'h7FFF); s.etc = 4'd2; sq.push_back(s);
        drain(4'b1101);

        // Count mismatch, then reset after the first term.
        step(1'b1, enc(16'h0003), 4'd3, 1'b1, acc);
        check("etc_accept", int'(acc), 1);
        step(1'b0, 24'h0, 4'h0, 1'b1, acc);
        do_reset();
        repeat (3) step(1'b0, 24'h0, 4'h0, 1'b1, acc);

        // Randomized traffic with occasional mid-stream reset.
        for (int w = 0; w < 400; w++) begin
            if (w % 2 == 0) s.bpr = enc(16'($urandom));
            else            s.bpr = 24'($urandom);
            if ($urandom_range(0, 3) == 0) s.bpr[5:0] = 6'h0;
            s.etc = ($urandom_range(0, 7) == 0) ? 4'($urandom) : ones(s.bpr);
            sq.push_back(s);
        end
        c = 0;
        while ((sq.size() != 0 || q.size() != 0) && c < 20000) begin
            logic iv, ordy;
            iv   = (sq.size() != 0) && ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            step(iv, iv ? sq[0].bpr : 24'($urandom), iv ? sq[0].etc : 4'($urandom), ordy, acc);
            if (acc) void'(sq.pop_front());
            if ($urandom_range(0, 599) == 0) do_reset();
            c++;
        end
        if (c >= 20000) check("random_timeout", 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
